coredma_cache_buf_ctrl: RTL and testbench

- Sequencing controller for the CoreDMA SRAM cache: presents the dual-port cache RAM as a first-word-fall-through FIFO between the fill side (DMA read-master data returning from the source) and the drain side (DMA write-master data going to the destination).
- Owns the write/read pointers, occupancy and prefetch of the 1-cycle-latency RAM read port, plus a 2-entry output buffer so drain backpressure never stalls the RAM pipeline.
- Sits between the DMA channel datapath and the cache RAM instance; drives every RAM port except clock and reset.

---
 rtl/coredma_cache_pkg.sv | 14 +
 rtl/coredma_cache_obuf.sv | 71 +++++++
 rtl/coredma_cache_buf_ctrl.sv | 97 +++++++++
 tb/tb_coredma_cache_buf_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/coredma_cache_pkg.sv
// Shared defaults and output-buffer state encoding for the CoreDMA cache controller.
package coredma_cache_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_e;

endpackage

// File: rtl/coredma_cache_obuf.sv
// Two-entry output buffer behind the 1-cycle RAM read port. A word arriving
// while the buffer is empty is presented straight to the drain side, so a
// streaming FIFO sees neither an extra cycle of latency nor a bubble.
module coredma_cache_obuf
  import coredma_cache_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cnt
);

  ob_state_e        state, state_nxt;
  logic [WIDTH-1:0] head, tail;
  logic             pop, pop_reg, load;

  assign out_valid = (state != OB_EMPTY) | in_valid;
  assign out_data  = (state != OB_EMPTY) ? head : (in_valid ? in_data : '0);
  assign cnt       = state;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OB_EMPTY;
    else        state <= state_nxt;
  end

  // next state: a pop only leaves the registers when they held the head;
  // a bypassed word taken on arrival never gets loaded
  always_comb begin
    pop       = out_valid & out_ready;
    pop_reg   = pop & (state != OB_EMPTY);
    load      = in_valid & ~((state == OB_EMPTY) & pop);
    state_nxt = state;
    case (state)
      OB_EMPTY: if (load) state_nxt = OB_ONE;
      OB_ONE: begin
        if (load & ~pop_reg)      state_nxt = OB_TWO;
        else if (~load & pop_reg) state_nxt = OB_EMPTY;
      end
      OB_TWO:   if (pop_reg) state_nxt = OB_ONE;
      default:  state_nxt = OB_EMPTY;
    endcase
    if (flush) state_nxt = OB_EMPTY;
  end

  // data registers; head is always the oldest word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      case (state)
        OB_EMPTY: if (load) head <= in_data;
        OB_ONE: begin
          if (load & pop_reg) head <= in_data;
          else if (load)      tail <= in_data;
        end
        OB_TWO:   if (pop_reg) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/coredma_cache_buf_ctrl.sv
// Cache RAM sequencing: presents the dual-port cache as a FWFT FIFO between
// the DMA fill and drain sides. Owns pointers, RAM occupancy and read prefetch.
module coredma_cache_buf_ctrl
  import coredma_cache_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic [WIDTH-1:0] fill_data,
  output logic             drain_valid,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] drain_data,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   ram_cnt;
  logic          rd_inflight;
  logic          rdy_en;
  logic [1:0]    obuf_cnt;
  logic          fill_hs;

  // rdy_en keeps fill_ready (and hence ram_wen) low while in reset
  assign fill_ready = rdy_en & (ram_cnt < DEPTH_C) & ~flush;
  assign fill_hs    = fill_valid & fill_ready;
  assign full       = rdy_en & ~fill_ready & ~flush;

  assign ram_wen    = fill_hs;
  assign ram_waddr  = wptr;
  assign ram_wdata  = fill_data;

  // at most two words downstream of the RAM, so the buffer can never overflow
  assign ram_ren    = (ram_cnt != '0) & ((obuf_cnt + {1'b0, rd_inflight}) < 2'd2) & ~flush;
  assign ram_raddr  = rptr;

  assign level = ram_cnt + (AW+1)'(rd_inflight) + (AW+1)'(obuf_cnt);
  assign empty = (level == '0);

  // fill side opens on the first edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // pointers, RAM occupancy and read-in-flight flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (fill_hs) wptr <= wptr + AW'(1);
      if (ram_ren) rptr <= rptr + AW'(1);
      rd_inflight <= ram_ren;
      case ({fill_hs, ram_ren})
        2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  coredma_cache_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk       (clock),
    .rst_n     (reset_n),
    .flush     (flush),
    .in_valid  (rd_inflight),
    .in_data   (ram_rdata),
    .out_ready (drain_ready),
    .out_valid (drain_valid),
    .out_data  (drain_data),
    .cnt       (obuf_cnt)
  );

endmodule

// File: tb/tb_coredma_cache_buf_ctrl.sv
// Directed bench for the cache buffer controller with a behavioural 1-cycle RAM.
module tb_coredma_cache_buf_ctrl;

  localparam int WIDTH = 128;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             fill_valid = 1'b0;
  logic             fill_ready;
  logic [WIDTH-1:0] fill_data = '0;
  logic             drain_valid;
  logic             drain_ready = 1'b0;
  logic [WIDTH-1:0] drain_data;
  logic [AW:0]      level;
  logic             empty, full;
  logic             ram_wen, ram_ren;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata = '0;
  logic [WIDTH-1:0] mem [DEPTH];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  coredma_cache_buf_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
    .level(level), .empty(empty), .full(full),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  task test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if (drain_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain_valid got %0b exp 0", drain_valid); end
    n_chk++; if (level !== 8'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level); end
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rst_flags got e=%0b f=%0b exp e=1 f=0", empty, full); end
    n_chk++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL rst_ram got wen=%0b ren=%0b exp 0 0", ram_wen, ram_ren); end
    n_chk++; if (drain_data !== '0) begin n_fail++; $display("FAIL rst_drain_data got %0h exp 0", drain_data); end
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fill_ready got %0b exp 1", fill_ready); end
  endtask

  task test_single;
    @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(8'hA5); drain_ready = 1'b1;
    @(negedge clock);
    n_chk++; if (ram_wen !== 1'b1 || ram_waddr !== 7'd0 || ram_wdata !== WIDTH'(8'hA5)) begin n_fail++; $display("FAIL single_wr got wen=%0b a=%0d d=%0h exp 1 0 a5", ram_wen, ram_waddr, ram_wdata); end
    @(posedge clock); #1 fill_valid = 1'b0;
    @(negedge clock);
    n_chk++; if (level !== 8'd1 || drain_valid !== 1'b0 || ram_ren !== 1'b1) begin n_fail++; $display("FAIL single_n1 got lvl=%0d dv=%0b ren=%0b exp 1 0 1", level, drain_valid, ram_ren); end
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++; if (level !== 8'd1 || drain_valid !== 1'b1 || drain_data !== WIDTH'(8'hA5)) begin n_fail++; $display("FAIL single_n2 got lvl=%0d dv=%0b d=%0h exp 1 1 a5", level, drain_valid, drain_data); end
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++; if (level !== 8'd0 || empty !== 1'b1 || drain_valid !== 1'b0) begin n_fail++; $display("FAIL single_n3 got lvl=%0d e=%0b dv=%0b exp 0 1 0", level, empty, drain_valid); end
    @(posedge clock); #1 drain_ready = 1'b0;
  endtask

  task test_backpressure;
    int acc;
    acc = 0;
    drain_ready = 1'b0;
    repeat (140) begin
      @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(acc);
      @(negedge clock);
      if (fill_ready) acc++;
    end
    n_chk++; if (acc !== 130) begin n_fail++; $display("FAIL bp_accepted got %0d exp 130", acc); end
    n_chk++; if (fill_ready !== 1'b0 || full !== 1'b1 || level !== 8'd130) begin n_fail++; $display("FAIL bp_full got rdy=%0b full=%0b lvl=%0d exp 0 1 130", fill_ready, full, level); end
    for (int i = 0; i < 130; i++) begin
      @(posedge clock); #1 fill_valid = 1'b0; drain_ready = 1'b1;
      @(negedge clock);
      n_chk++; if (drain_valid !== 1'b1 || drain_data !== WIDTH'(i)) begin n_fail++; $display("FAIL bp_drain[%0d] got v=%0b d=%0h exp 1 %0h", i, drain_valid, drain_data, i); end
    end
    @(posedge clock); #1 drain_ready = 1'b0;
    @(negedge clock);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty got %0b exp 1", empty); end
  endtask

  task test_stream;
    int sent, rcv, bubbles, wrapw, wrapr, first;
    sent = 0; rcv = 0; bubbles = 0; wrapw = 0; wrapr = 0; first = -1;
    for (int c = 0; c < 320; c++) begin
      @(posedge clock); #1 drain_ready = 1'b1; fill_valid = (sent < 300); fill_data = WIDTH'(1000 + sent);
      @(negedge clock);
      if (ram_wen && ram_waddr == 7'd127) wrapw++;
      if (ram_ren && ram_raddr == 7'd127) wrapr++;
      if (fill_valid && fill_ready) sent++;
      if (drain_valid) begin
        if (first < 0) first = c;
        n_chk++; if (drain_data !== WIDTH'(1000 + rcv)) begin n_fail++; $display("FAIL stream_data[%0d] got %0h exp %0h", rcv, drain_data, 1000 + rcv); end
        rcv++;
      end else if (rcv > 0 && rcv < 300) bubbles++;
    end
    n_chk++; if (rcv !== 300) begin n_fail++; $display("FAIL stream_count got %0d exp 300", rcv); end
    n_chk++; if (bubbles !== 0) begin n_fail++; $display("FAIL stream_bubbles got %0d exp 0", bubbles); end
    n_chk++; if (first !== 2) begin n_fail++; $display("FAIL stream_latency got %0d exp 2", first); end
    n_chk++; if (wrapw !== 2 || wrapr !== 2) begin n_fail++; $display("FAIL stream_wrap got w=%0d r=%0d exp 2 2", wrapw, wrapr); end
    @(posedge clock); #1 fill_valid = 1'b0; drain_ready = 1'b0;
  endtask

  task test_random;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_d;
    int sent, rcv, cyc;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 5000 && cyc < 40000) begin
      @(posedge clock); #1
      fill_valid  = (sent < 5000) && ($urandom_range(0, 3) != 0);
      drain_ready = ($urandom_range(0, 2) != 0);
      fill_data   = WIDTH'($urandom);
      @(negedge clock);
      cyc++;
      n_chk++; if (level !== (AW+1)'(sent - rcv) || level > 8'd130) begin n_fail++; $display("FAIL rand_level got %0d exp %0d", level, sent - rcv); end
      if (fill_valid && fill_ready) begin sb.push_back(fill_data); sent++; end
      if (drain_valid && drain_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : '1;
        n_chk++; if (drain_data !== exp_d) begin n_fail++; $display("FAIL rand_data[%0d] got %0h exp %0h", rcv, drain_data, exp_d); end
        rcv++;
      end
    end
    n_chk++; if (rcv !== 5000) begin n_fail++; $display("FAIL rand_timeout got %0d exp 5000", rcv); end
    @(posedge clock); #1 fill_valid = 1'b0; drain_ready = 1'b0;
  endtask

  task test_flush;
    drain_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(8'h50 + i);
    end
    @(posedge clock); #1 fill_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 drain_ready = 1'b1;
    @(negedge clock);
    n_chk++; if (drain_valid !== 1'b1 || drain_data !== WIDTH'(8'h50)) begin n_fail++; $display("FAIL flush_pop got v=%0b d=%0h exp 1 50", drain_valid, drain_data); end
    @(posedge clock); #1 drain_ready = 1'b0;
    @(negedge clock);
    n_chk++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL flush_ren got %0b exp 1", ram_ren); end
    @(posedge clock); #1 flush = 1'b1; fill_valid = 1'b1; fill_data = WIDTH'(8'hEE);
    @(negedge clock);
    n_chk++; if (level !== 8'd5 || drain_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got lvl=%0d dv=%0b exp 5 1", level, drain_valid); end
    n_chk++; if (fill_ready !== 1'b0 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL flush_block got rdy=%0b wen=%0b ren=%0b exp 0 0 0", fill_ready, ram_wen, ram_ren); end
    @(posedge clock); #1 flush = 1'b0; fill_valid = 1'b0;
    @(negedge clock);
    n_chk++; if (level !== 8'd0 || drain_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_post got lvl=%0d dv=%0b e=%0b exp 0 0 1", level, drain_valid, empty); end
    @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(8'h77);
    @(negedge clock);
    n_chk++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL flush_refill got %0b exp 1", fill_ready); end
    @(posedge clock); #1 fill_valid = 1'b0;
    @(negedge clock);
    n_chk++; if (drain_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale got %0b exp 0", drain_valid); end
    @(posedge clock); #1 drain_ready = 1'b1;
    @(negedge clock);
    n_chk++; if (drain_valid !== 1'b1 || drain_data !== WIDTH'(8'h77)) begin n_fail++; $display("FAIL flush_new got v=%0b d=%0h exp 1 77", drain_valid, drain_data); end
    @(posedge clock); #1 drain_ready = 1'b0;
    @(negedge clock);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_end got %0b exp 1", empty); end
  endtask

  task test_async_reset;
    drain_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(16'h200 + i);
    end
    @(negedge clock);
    n_chk++; if (drain_valid !== 1'b1 || ram_wen !== 1'b1) begin n_fail++; $display("FAIL ar_stream got dv=%0b wen=%0b exp 1 1", drain_valid, ram_wen); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (drain_valid !== 1'b0 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL ar_outs got dv=%0b wen=%0b ren=%0b exp 0 0 0", drain_valid, ram_wen, ram_ren); end
    n_chk++; if (level !== 8'd0 || drain_data !== '0) begin n_fail++; $display("FAIL ar_level got lvl=%0d d=%0h exp 0 0", level, drain_data); end
    @(negedge clock); reset_n = 1'b1; fill_valid = 1'b0;
    @(posedge clock); #1 fill_valid = 1'b1; fill_data = WIDTH'(8'h99);
    @(negedge clock);
    n_chk++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %0b exp 1", fill_ready); end
    @(posedge clock); #1 fill_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++; if (drain_valid !== 1'b1 || drain_data !== WIDTH'(8'h99)) begin n_fail++; $display("FAIL ar_resume got v=%0b d=%0h exp 1 99", drain_valid, drain_data); end
    @(posedge clock); #1 drain_ready = 1'b0;
    @(negedge clock);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got %0b exp 1", empty); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_stream;
    test_random;
    test_flush;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
